// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and port ownership codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way owner picker: a lone request wins outright; a tie goes to D under PRIO_D,
// otherwise to whichever port was not served last.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter bit PRIO_D = 1'b0
) (
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_owner,
  output owner_t owner
);

  always_comb begin
    owner = OWN_I;
    if (req_i && req_d) begin
      if (PRIO_D) begin
        owner = OWN_D;
      end else begin
        owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      end
    end else if (req_d) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/write-backs,
// running one aligned line burst of BURST beats per grant (IDLE -> BURST -> DONE).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST  = 4,
  parameter int AW     = 32,
  parameter int PRIO_D = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_wnext,
  output logic          d_done,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  localparam int BW  = $clog2(BURST);
  localparam int OFS = BW + 2;
  localparam logic [AW-1:0] LINE_MASK = {{(AW-OFS){1'b1}}, {OFS{1'b0}}};
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  state_t        r_state, w_state_nxt;
  owner_t        r_owner, r_last_owner, w_pick;
  logic          r_we;
  logic [AW-1:0] r_base;
  logic [BW-1:0] r_beat;
  logic          w_any_req;
  logic [AW-1:0] w_beat_ofs;

  assign w_any_req  = i_req | d_req;
  assign w_beat_ofs = {{(AW-OFS){1'b0}}, r_beat, 2'b00};

  rr_arb2 #(.PRIO_D(PRIO_D != 0)) u_pick (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_owner (r_last_owner),
    .owner      (w_pick)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_BURST;
      ST_BURST: if (mem_ready && (r_beat == LAST_BEAT)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // BURST is a power of two, so the beat counter wraps back to 0 on the last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner      <= OWN_I;
      r_last_owner <= OWN_D;
      r_we         <= 1'b0;
      r_base       <= '0;
      r_beat       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any_req) begin
          r_owner <= w_pick;
          r_we    <= (w_pick == OWN_D) & d_we;
          r_base  <= ((w_pick == OWN_D) ? d_addr : i_addr) & LINE_MASK;
          r_beat  <= '0;
        end
        ST_BURST: if (mem_ready) r_beat <= r_beat + BW'(1);
        ST_DONE:  r_last_owner <= r_owner;
        default:  ;
      endcase
    end
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    d_wnext   = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    mem_wdata = d_wdata;
    busy      = (r_state != ST_IDLE);
    if (r_state != ST_IDLE) begin
      i_gnt = (r_owner == OWN_I);
      d_gnt = (r_owner == OWN_D);
    end
    if (r_state == ST_BURST) begin
      mem_valid = 1'b1;
      mem_we    = r_we;
      mem_addr  = r_base + w_beat_ofs;
      i_rvalid  = mem_ready & ~r_we & (r_owner == OWN_I);
      d_rvalid  = mem_ready & ~r_we & (r_owner == OWN_D);
      d_wnext   = mem_ready &  r_we & (r_owner == OWN_D);
    end
    if (r_state == ST_DONE) begin
      i_done = (r_owner == OWN_I);
      d_done = (r_owner == OWN_D);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for tie order, reset abort
// and D priority, then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int BURST = 4;
  localparam int AW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [31:0]   d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
  logic          i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wnext, d_done;
  logic          mem_valid, mem_we, busy;

  mem_arbiter #(.BURST(BURST), .AW(AW), .PRIO_D(0)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wnext(d_wnext), .d_done(d_done),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // Second instance with D priority on ties
  logic          p_rst, p_ireq, p_dreq;
  logic [AW-1:0] p_mem_addr;
  logic [31:0]   p_i_rdata, p_d_rdata, p_mem_wdata;
  logic          p_i_gnt, p_i_rvalid, p_i_done, p_d_gnt, p_d_rvalid, p_d_wnext, p_d_done;
  logic          p_mem_valid, p_mem_we, p_busy;

  mem_arbiter #(.BURST(BURST), .AW(AW), .PRIO_D(1)) u_dut_prio (
    .clk(clk), .rst(p_rst),
    .i_req(p_ireq), .i_addr(32'h0000_0100), .i_gnt(p_i_gnt), .i_rvalid(p_i_rvalid),
    .i_rdata(p_i_rdata), .i_done(p_i_done),
    .d_req(p_dreq), .d_we(1'b0), .d_addr(32'h0000_0440), .d_wdata(32'h0),
    .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata), .d_wnext(p_d_wnext),
    .d_done(p_d_done), .mem_valid(p_mem_valid), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(32'h1234_5678), .mem_ready(1'b1), .busy(p_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one burst is a count of completed beats 0..BURST; BURST means done phase.
  bit          m_busy, m_own_d, m_we, m_last_d;
  int          m_beats;
  logic [31:0] m_base;

  // flag order: busy i_gnt d_gnt mem_valid i_rvalid d_rvalid d_wnext i_done d_done
  logic [8:0]  a_flags, e_flags;
  logic [31:0] a_addr;
  logic        a_we;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic        rd;
    logic [8:0]  flags;
    logic [31:0] addr;
    logic        we;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic rd,
                              input logic [8:0] flags, input logic [31:0] addr,
                              input logic we);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.rd = rd;
    v.flags = flags; v.addr = addr; v.we = we;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic rd);
    logic        ev, ed;
    logic [31:0] ea;
    rst = rn; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da;
    mem_ready = rd; mem_rdata = $urandom; d_wdata = $urandom;
    @(negedge clk);
    ev = m_busy && (m_beats < BURST);
    ed = m_busy && (m_beats == BURST);
    ea = m_base + 32'(4 * m_beats);
    e_flags = {m_busy, m_busy && !m_own_d, m_busy && m_own_d, ev,
               ev && rd && !m_we && !m_own_d, ev && rd && !m_we && m_own_d,
               ev && rd && m_we, ed && !m_own_d, ed && m_own_d};
    a_flags = {busy, i_gnt, d_gnt, mem_valid, i_rvalid, d_rvalid, d_wnext, i_done, d_done};
    a_addr  = mem_addr;
    a_we    = mem_we;
    chk("flags", 32'(a_flags), 32'(e_flags));
    if (ev) begin
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", 32'(mem_we), 32'(m_we));
    end
    if (e_flags[4]) chk("i_rdata", i_rdata, mem_rdata);
    if (e_flags[3]) chk("d_rdata", d_rdata, mem_rdata);
    chk("mem_wdata", mem_wdata, d_wdata);
    if (!rn) begin
      m_busy = 0; m_beats = 0; m_last_d = 1;
    end else if (!m_busy) begin
      if (ir || dr) begin
        m_own_d = (ir && dr) ? !m_last_d : dr;
        m_we    = m_own_d && dw;
        m_base  = (m_own_d ? da : ia) & ~32'(BURST * 4 - 1);
        m_beats = 0;
        m_busy  = 1;
      end
    end else if (m_beats < BURST) begin
      if (rd) m_beats++;
    end else begin
      m_last_d = m_own_d;
      m_busy   = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  logic        r_ir, r_dr, r_dw, r_rn;
  logic [31:0] r_ia, r_da;
  int          nb, nd, ni;

  initial begin
    rst = 0; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0;
    d_wdata = 0; mem_rdata = 0; mem_ready = 0;
    p_rst = 0; p_ireq = 0; p_dreq = 0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 0; m_beats = 0; m_last_d = 1; m_own_d = 0; m_we = 0; m_base = 0;

    // I refill with ready tied high; ready also high while idle and in DONE
    add(1, 32'h104, 0, 0, 0, 1, 9'b000000000, 0, 0);
    add(1, 32'h104, 0, 0, 0, 1, 9'b110110000, 32'h100, 0);
    add(1, 32'h104, 0, 0, 0, 1, 9'b110110000, 32'h104, 0);
    add(1, 32'h104, 0, 0, 0, 1, 9'b110110000, 32'h108, 0);
    add(1, 32'h104, 0, 0, 0, 1, 9'b110110000, 32'h10C, 0);
    add(1, 32'h104, 0, 0, 0, 1, 9'b110000010, 0, 0);
    add(0, 32'h104, 0, 0, 0, 1, 9'b000000000, 0, 0);
    add(0, 0,       0, 0, 0, 0, 9'b000000000, 0, 0);
    // D write-back with ready every second cycle
    add(0, 0, 1, 1, 32'h2000, 0, 9'b000000000, 0, 0);
    add(0, 0, 1, 1, 32'h2000, 0, 9'b101100000, 32'h2000, 1);
    add(0, 0, 1, 1, 32'h2000, 1, 9'b101100100, 32'h2000, 1);
    add(0, 0, 1, 1, 32'h2000, 0, 9'b101100000, 32'h2004, 1);
    add(0, 0, 1, 1, 32'h2000, 1, 9'b101100100, 32'h2004, 1);
    add(0, 0, 1, 1, 32'h2000, 0, 9'b101100000, 32'h2008, 1);
    add(0, 0, 1, 1, 32'h2000, 1, 9'b101100100, 32'h2008, 1);
    add(0, 0, 1, 1, 32'h2000, 0, 9'b101100000, 32'h200C, 1);
    add(0, 0, 1, 1, 32'h2000, 1, 9'b101100100, 32'h200C, 1);
    add(0, 0, 1, 1, 32'h2000, 1, 9'b101000001, 0, 0);
    add(0, 0, 0, 0, 32'h2000, 1, 9'b000000000, 0, 0);
    // next burst must restart at beat 0 with an unaligned request address
    add(1, 32'h3FC, 0, 0, 0, 1, 9'b000000000, 0, 0);
    add(1, 32'h3FC, 0, 0, 0, 1, 9'b110110000, 32'h3F0, 0);
    add(1, 32'h3FC, 0, 0, 0, 1, 9'b110110000, 32'h3F4, 0);
    add(1, 32'h3FC, 0, 0, 0, 1, 9'b110110000, 32'h3F8, 0);
    add(1, 32'h3FC, 0, 0, 0, 1, 9'b110110000, 32'h3FC, 0);
    add(1, 32'h3FC, 0, 0, 0, 1, 9'b110000010, 0, 0);
    add(0, 32'h3FC, 0, 0, 0, 1, 9'b000000000, 0, 0);

    foreach (vq[k]) begin
      step(1, vq[k].ir, vq[k].ia, vq[k].dr, vq[k].dw, vq[k].da, vq[k].rd);
      chk("tbl_flags", 32'(a_flags), 32'(vq[k].flags));
      if (vq[k].flags[5]) begin
        chk("tbl_addr", a_addr, vq[k].addr);
        chk("tbl_we", 32'(a_we), 32'(vq[k].we));
      end
    end

    // Both held after reset: I first, then strict alternation
    step(0, 0, 0, 0, 0, 0, 0);
    nb = 0;
    for (int k = 0; k < 24; k++) begin
      step(1, 1, 32'h1000, 1, 0, 32'h5000, 1);
      if (a_flags[1] || a_flags[0]) begin
        chk("alt_order", 32'(a_flags[0]), 32'(nb % 2));
        nb++;
      end
    end
    chk("alt_count", nb, 4);

    // Reset during beat 2 of a D read
    step(1, 0, 0, 1, 0, 32'h500, 1);
    step(1, 0, 0, 1, 0, 32'h500, 1);
    step(1, 0, 0, 1, 0, 32'h500, 1);
    step(0, 0, 0, 1, 0, 32'h500, 1);
    step(1, 1, 32'h600, 0, 0, 0, 1);
    chk("rst_busy", 32'(a_flags[8]), 0);
    chk("rst_valid", 32'(a_flags[5]), 0);
    chk("rst_ddone", 32'(a_flags[0]), 0);
    step(1, 1, 32'h600, 0, 0, 0, 1);
    chk("post_rst_addr", a_addr, 32'h600);
    chk("post_rst_ignt", 32'(a_flags[7]), 1);
    for (int k = 0; k < 4; k++) step(1, 1, 32'h600, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);

    // D priority: I starves while both requests stay high
    p_ireq = 1; p_dreq = 1;
    @(posedge clk);
    #1;
    p_rst = 1;
    nd = 0; ni = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (p_d_done) nd++;
      if (p_i_gnt || p_i_done || p_i_rvalid) ni++;
    end
    chk("prio_d_bursts", nd, 3);
    chk("prio_i_starved", ni, 0);
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    r_ir = 0; r_dr = 0; r_dw = 0; r_ia = 0; r_da = 0;
    for (int k = 0; k < 3000; k++) begin
      r_rn = ($urandom_range(0, 199) != 0);
      if (e_flags[1]) r_ir = 0;
      else if (!r_ir && $urandom_range(0, 3) == 0) begin r_ir = 1; r_ia = $urandom; end
      else if (r_ir && $urandom_range(0, 39) == 0) r_ir = 0;
      if (e_flags[0]) r_dr = 0;
      else if (!r_dr && $urandom_range(0, 3) == 0) begin
        r_dr = 1; r_da = $urandom; r_dw = 1'($urandom_range(0, 1));
      end else if (r_dr && $urandom_range(0, 39) == 0) r_dr = 0;
      step(r_rn, r_ir, r_ia, r_dr, r_dw, r_da, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
